frame_receiver: RTL and testbench

- Byte-level frame parser directly downstream of the bit-serial transceiver.
- Consumes each completed received byte (transceiver dataout, qualified by its done pulse) and locates frames of the form SYNC, LEN, payload[LEN], CHECKSUM.
- Validates each frame, buffers the payload, and holds it for a host-side reader until acknowledged.
- Reports length, checksum, overrun and inter-byte timeout errors as single-cycle pulses.

---
 rtl/frame_receiver.sv | 171 +++++++++++++++++
 tb/tb_frame_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_receiver.sv
// Byte-level frame parser: finds SYNC, LEN, payload[LEN], CHECKSUM frames in the
// transceiver byte stream, buffers a validated payload and holds it until acknowledged.
module frame_receiver #(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         TIMEOUT = 1024
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [7:0]                   byte_in,
   input  logic                         byte_valid,
   output logic                         frame_ready,
   output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
   input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
   output logic [7:0]                   rd_data,
   input  logic                         frame_ack,
   output logic                         busy,
   output logic                         err_length,
   output logic                         err_checksum,
   output logic                         err_overrun,
   output logic                         err_timeout
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = $clog2(MAX_LEN);
   localparam int GW = $clog2(TIMEOUT + 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_HOLD
   } state_t;

   state_t        r_state, w_state_next;
   logic [LW-1:0] r_len, w_len_next;
   logic [LW-1:0] r_cnt, w_cnt_next;
   logic [LW-1:0] r_frame_len, w_frame_len_next;
   logic [7:0]    r_sum, w_sum_next;
   logic [GW-1:0] r_gap, w_gap_next;
   logic          r_frame_ready, w_frame_ready_next;
   logic          r_err_length, w_err_length_next;
   logic          r_err_checksum, w_err_checksum_next;
   logic          r_err_overrun, w_err_overrun_next;
   logic          r_err_timeout, w_err_timeout_next;
   logic          w_busy;
   logic          w_buf_we;
   logic [7:0]    r_buf [MAX_LEN];

   assign w_busy = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);

   always_comb begin
      w_state_next        = r_state;
      w_len_next          = r_len;
      w_cnt_next          = r_cnt;
      w_sum_next          = r_sum;
      w_frame_len_next    = r_frame_len;
      w_frame_ready_next  = r_frame_ready;
      w_gap_next          = '0;
      w_err_length_next   = 1'b0;
      w_err_checksum_next = 1'b0;
      w_err_overrun_next  = 1'b0;
      w_err_timeout_next  = 1'b0;
      w_buf_we            = 1'b0;

      // Idle cycles inside a frame; any byte_valid keeps the gap counter at zero.
      if (w_busy && !byte_valid) begin
         if (r_gap == GAP_LAST) begin
            w_err_timeout_next = 1'b1;
            w_state_next       = ST_HUNT;
         end else begin
            w_gap_next = r_gap + 1'b1;
         end
      end

      case (r_state)
         ST_HUNT: begin
            if (byte_valid && byte_in == SYNC) w_state_next = ST_LEN;
         end
         ST_LEN: begin
            if (byte_valid) begin
               if (byte_in == 8'h00 || byte_in > MAX_LEN_B) begin
                  w_err_length_next = 1'b1;
                  w_state_next      = ST_HUNT;
               end else begin
                  w_len_next   = byte_in[LW-1:0];
                  w_cnt_next   = '0;
                  w_sum_next   = byte_in;
                  w_state_next = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (byte_valid) begin
               w_buf_we   = 1'b1;
               w_sum_next = r_sum + byte_in;
               w_cnt_next = r_cnt + 1'b1;
               if (r_cnt == r_len - LW'(1)) w_state_next = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (byte_valid) begin
               if (byte_in == r_sum) begin
                  w_frame_ready_next = 1'b1;
                  w_frame_len_next   = r_len;
                  w_state_next       = ST_HOLD;
               end else begin
                  w_err_checksum_next = 1'b1;
                  w_state_next        = ST_HUNT;
               end
            end
         end
         ST_HOLD: begin
            // A byte arriving with the ack is still dropped, never parsed as SYNC.
            if (byte_valid) w_err_overrun_next = 1'b1;
            if (frame_ack) begin
               w_frame_ready_next = 1'b0;
               w_frame_len_next   = '0;
               w_state_next       = ST_HUNT;
            end
         end
         default: w_state_next = ST_HUNT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_HUNT;
         r_len          <= '0;
         r_cnt          <= '0;
         r_sum          <= '0;
         r_gap          <= '0;
         r_frame_len    <= '0;
         r_frame_ready  <= 1'b0;
         r_err_length   <= 1'b0;
         r_err_checksum <= 1'b0;
         r_err_overrun  <= 1'b0;
         r_err_timeout  <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_len          <= w_len_next;
         r_cnt          <= w_cnt_next;
         r_sum          <= w_sum_next;
         r_gap          <= w_gap_next;
         r_frame_len    <= w_frame_len_next;
         r_frame_ready  <= w_frame_ready_next;
         r_err_length   <= w_err_length_next;
         r_err_checksum <= w_err_checksum_next;
         r_err_overrun  <= w_err_overrun_next;
         r_err_timeout  <= w_err_timeout_next;
      end
   end

   // Payload store has no reset; rd_data is masked until a frame is held.
   always_ff @(posedge clock) begin
      if (w_buf_we) r_buf[r_cnt[AW-1:0]] <= byte_in;
   end

   assign rd_data      = (r_frame_ready && (LW'(rd_addr) < r_frame_len)) ? r_buf[rd_addr] : 8'h00;
   assign frame_ready  = r_frame_ready;
   assign frame_len    = r_frame_len;
   assign busy         = w_busy;
   assign err_length   = r_err_length;
   assign err_checksum = r_err_checksum;
   assign err_overrun  = r_err_overrun;
   assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: a table of frames plus hand-written corner sequences;
// every error pulse and frame_ready edge is matched against a queue of expected events.
module tb_frame_receiver;

   localparam int MAX_LEN = 16;
   localparam int TIMEOUT = 1024;

   localparam logic [2:0] EV_NONE = 3'd0;
   localparam logic [2:0] EV_LEN  = 3'd1;
   localparam logic [2:0] EV_CSUM = 3'd2;
   localparam logic [2:0] EV_OVR  = 3'd3;
   localparam logic [2:0] EV_TO   = 3'd4;
   localparam logic [2:0] EV_RDY  = 3'd5;
   localparam logic [2:0] EV_REL  = 3'd6;

   typedef struct packed {
      logic [2:0] kind;
      int         due;
      int         len;
   } exp_t;

   typedef struct packed {
      int         start;
      int         n;
      logic [2:0] ev;
      int         len;
      int         off;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       frame_ready;
   logic [4:0] frame_len;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       frame_ack;
   logic       busy;
   logic       err_length, err_checksum, err_overrun, err_timeout;

   int         nchecks = 0;
   int         nerr    = 0;
   int         cyc     = 0;
   logic       prev_ready = 1'b0;
   exp_t       expq[$];
   logic [7:0] pool[$];
   vec_t       tbl[$];

   frame_receiver #(.MAX_LEN(MAX_LEN), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
      .clock(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .frame_ready(frame_ready), .frame_len(frame_len), .rd_addr(rd_addr), .rd_data(rd_data),
      .frame_ack(frame_ack), .busy(busy), .err_length(err_length), .err_checksum(err_checksum),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input logic [2:0] k, input int due, input int len);
      exp_t e;
      e.kind = k;
      e.due  = due;
      e.len  = len;
      expq.push_back(e);
   endtask

   task automatic observe(input logic [2:0] k);
      exp_t e;
      if (expq.size() == 0) begin
         nchecks++;
         nerr++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
      end else begin
         e = expq.pop_front();
         $display("event kind=%0d cycle=%0d frame_len=%0d", k, cyc, frame_len);
         chk("event_kind", int'(k), int'(e.kind));
         chk("event_cycle", cyc, e.due);
         if (k == EV_RDY) chk("event_frame_len", int'(frame_len), e.len);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (err_length)   observe(EV_LEN);
      if (err_checksum) observe(EV_CSUM);
      if (err_overrun)  observe(EV_OVR);
      if (err_timeout)  observe(EV_TO);
      if (frame_ready && !prev_ready) observe(EV_RDY);
      if (!frame_ready && prev_ready) observe(EV_REL);
      prev_ready = frame_ready;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      byte_in    = 8'h00;
   endtask

   task automatic ack();
      expect_ev(EV_REL, cyc + 1, 0);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk("len_after_ack", int'(frame_len), 0);
      chk("busy_after_ack", int'(busy), 0);
   endtask

   task automatic rd_chk(input int a, input int exp);
      rd_addr = 4'(a);
      #1;
      chk("rd_data", int'(rd_data), exp);
   endtask

   task automatic add_vec(input int n, input logic [2:0] ev, input int len, input int off);
      vec_t v;
      v.start = pool.size() - n;
      v.n     = n;
      v.ev    = ev;
      v.len   = len;
      v.off   = off;
      tbl.push_back(v);
   endtask

   initial begin
      logic [7:0] sum;
      logic [7:0] b;
      int         expd;

      reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; rd_addr = 4'd0; frame_ack = 1'b0;

      pool = {pool, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};  add_vec(6, EV_RDY, 3, 2);
      pool = {pool, 8'h00, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};  add_vec(6, EV_RDY, 1, 4);
      pool = {pool, 8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF};         add_vec(5, EV_CSUM, 0, 0);
      pool = {pool, 8'hA5, 8'h01, 8'h05, 8'h06};                add_vec(4, EV_RDY, 1, 2);
      pool = {pool, 8'hA5, 8'h00};                              add_vec(2, EV_LEN, 0, 0);
      pool = {pool, 8'hA5, 8'h11};                              add_vec(2, EV_LEN, 0, 0);
      pool = {pool, 8'hA5, 8'hA5};                              add_vec(2, EV_LEN, 0, 0);
      pool = {pool, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};         add_vec(5, EV_RDY, 2, 2);
      pool.push_back(8'hA5);
      pool.push_back(8'h10);
      sum = 8'h10;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom_range(0, 255));
         sum += b;
         pool.push_back(b);
      end
      pool.push_back(sum);
      add_vec(19, EV_RDY, 16, 2);

      idle(2);
      chk("rst_frame_ready", int'(frame_ready), 0);
      chk("rst_frame_len", int'(frame_len), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_errors", int'({err_length, err_checksum, err_overrun, err_timeout}), 0);
      reset = 1'b0;
      idle(2);

      foreach (tbl[i]) begin
         for (int j = 0; j < tbl[i].n; j++) begin
            if (j == tbl[i].n - 1 && tbl[i].ev != EV_NONE) expect_ev(tbl[i].ev, cyc + 1, tbl[i].len);
            send(pool[tbl[i].start + j]);
         end
         idle(2);
         chk("vec_frame_ready", int'(frame_ready), int'(tbl[i].ev == EV_RDY));
         chk("vec_busy", int'(busy), 0);
         if (tbl[i].ev == EV_RDY) begin
            chk("vec_frame_len", int'(frame_len), tbl[i].len);
            for (int a = 0; a < MAX_LEN; a++) begin
               expd = (a < tbl[i].len) ? int'(pool[tbl[i].start + tbl[i].off + a]) : 0;
               rd_chk(a, expd);
            end
            ack();
         end else begin
            chk("vec_frame_len", int'(frame_len), 0);
            rd_chk(0, 0);
         end
         idle(1);
      end

      // Overrun in HOLD, HOLD ignores the gap timer, then byte together with ack.
      send(8'hA5); send(8'h02); send(8'h33); send(8'h44);
      expect_ev(EV_RDY, cyc + 1, 2);
      send(8'h79);
      idle(TIMEOUT + 5);
      expect_ev(EV_OVR, cyc + 1, 0);
      send(8'h42);
      chk("ovr_frame_ready", int'(frame_ready), 1);
      chk("ovr_frame_len", int'(frame_len), 2);
      rd_chk(0, 8'h33);
      rd_chk(1, 8'h44);
      expect_ev(EV_OVR, cyc + 1, 0);
      expect_ev(EV_REL, cyc + 1, 0);
      byte_in = 8'hA5; byte_valid = 1'b1; frame_ack = 1'b1;
      tick();
      byte_valid = 1'b0; frame_ack = 1'b0; byte_in = 8'h00;
      chk("ovr_ack_busy", int'(busy), 0);
      send(8'hA5); send(8'h01); send(8'h01);
      expect_ev(EV_RDY, cyc + 1, 1);
      send(8'h02);
      rd_chk(0, 8'h01);
      ack();

      // Ack outside HOLD has no effect.
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      send(8'hA5);
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      send(8'h01); send(8'h09);
      expect_ev(EV_RDY, cyc + 1, 1);
      send(8'h0A);
      rd_chk(0, 8'h09);
      ack();

      // Inter-byte timeout.
      send(8'hA5);
      chk("to_busy_len", int'(busy), 1);
      send(8'h02);
      expect_ev(EV_TO, cyc + 1 + TIMEOUT, 0);
      send(8'h10);
      idle(TIMEOUT - 1);
      chk("to_busy_before", int'(busy), 1);
      idle(6);
      chk("to_busy_after", int'(busy), 0);
      chk("to_pending", expq.size(), 0);

      // Reset mid-frame aborts silently.
      send(8'hA5); send(8'h02); send(8'h10);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2_busy", int'(busy), 0);
      chk("rst2_ready", int'(frame_ready), 0);
      chk("rst2_errors", int'({err_length, err_checksum, err_overrun, err_timeout}), 0);
      idle(TIMEOUT + 4);
      send(8'hA5); send(8'h01); send(8'h05);
      expect_ev(EV_RDY, cyc + 1, 1);
      send(8'h06);
      rd_chk(0, 8'h05);
      ack();
      idle(3);

      chk("pending_events", expq.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
